bus_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one datapath resource among N requesters. The resource is a shared bus whose source-select and enable terms are OR-combined from the requester drivers in the standard-cell netlist. Grants are registered and one-hot, with a single-cycle turnaround between owners so OR-combined drivers never overlap. An optional hold-timeout watchdog forcibly revokes ownership from a requester that never releases.

---
 rtl/bus_rr_arbiter.sv | 80 ++++++++
 tb/tb_bus_rr_arbiter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: registered one-hot round-robin bus arbiter with one-cycle turnaround; define BUS_RR_ARB_TIMEOUT_EN for the hold watchdog
module bus_rr_arbiter #(
  parameter int N = 4,
  parameter int IDW = 2,
  parameter int MAX_HOLD = 16,
  parameter int CW = 5
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           busy,
  output logic           timeout
);
  localparam logic IDLE = 1'b0;
  localparam logic GRANT = 1'b1;
  if (N < 2 || N > 16 || (1 << IDW) < N || MAX_HOLD < 1 || (1 << CW) <= MAX_HOLD) begin : g_bad_params
    $error("bus_rr_arbiter: inconsistent parameters");
  end
  logic           state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] pick;
  logic [IDW-1:0] nxt;
  logic           found;
  logic           force_rel;
  logic           release_now;
  assign busy = state;
  assign nxt = IDW'((int'(pick) + 1) % N);
  assign release_now = !req[gnt_id] || force_rel;
  // descending scan so the lowest offset from ptr is the one left standing
  always_comb begin
    found = 1'b0;
    pick = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N]) begin
        found = 1'b1;
        pick = IDW'((int'(ptr) + i) % N);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      gnt <= '0;
      gnt_id <= '0;
      ptr <= '0;
    end else if (state == IDLE) begin
      if (found) begin
        state <= GRANT;
        gnt <= N'(1) << pick;
        gnt_id <= pick;
        ptr <= nxt;
      end
    end else if (release_now) begin
      state <= IDLE;
      gnt <= '0;
      gnt_id <= '0;
    end
  end
`ifdef BUS_RR_ARB_TIMEOUT_EN
  logic [CW-1:0] hold;
  logic          to_q;
  assign force_rel = hold == CW'(MAX_HOLD);
  assign timeout = to_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      hold <= '0;
      to_q <= 1'b0;
    end else begin
      to_q <= state == GRANT && req[gnt_id] && force_rel;
      hold <= state == IDLE ? (found ? CW'(1) : '0) :
              release_now ? '0 : (hold == '1 ? hold : hold + CW'(1));
    end
  end
`else
  assign force_rel = 1'b0;
  assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb_bus_rr_arbiter: directed and random checks of bus_rr_arbiter against a tenure-level reference model
module tb_bus_rr_arbiter;
  localparam int N = 4;
  localparam int IDW = 2;
  localparam int MAX_HOLD = 16;
  localparam int CW = 5;
`ifdef BUS_RR_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] gnt;
  logic [IDW-1:0] gnt_id;
  logic busy;
  logic timeout;
  int vectors = 0;
  int errors = 0;
  int m_own = -1;
  int m_ptr = 0;
  int m_hold = 0;
  bit m_to = 1'b0;
  int wc[N];
  int n_to = 0;
  logic [N-1:0] prev = '0;
  bus_rr_arbiter #(.N(N), .IDW(IDW), .MAX_HOLD(MAX_HOLD), .CW(CW)) dut (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .timeout(timeout)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // one arbitration decision per edge, phrased in terms of owners and tenures
  task automatic model_edge(input logic [N-1:0] r, input bit rs);
    int p;
    m_to = 1'b0;
    if (rs) begin
      m_own = -1; m_ptr = 0; m_hold = 0;
    end else if (m_own < 0) begin
      p = -1;
      for (int i = 0; i < N; i++) if (p < 0 && r[(m_ptr + i) % N]) p = (m_ptr + i) % N;
      if (p >= 0) begin m_own = p; m_ptr = (p + 1) % N; m_hold = 1; end
    end else if (!r[m_own]) begin
      m_own = -1;
    end else if (TO_EN && m_hold >= MAX_HOLD) begin
      m_own = -1; m_to = 1'b1;
    end else begin
      m_hold++;
    end
  endtask
  task automatic step(input logic [N-1:0] r, input bit rs);
    logic [N-1:0] eg;
    bit new_ten;
    @(negedge clk);
    req = r;
    reset = rs;
    @(posedge clk);
    model_edge(r, rs);
    #1;
    eg = (m_own < 0) ? '0 : N'(1) << m_own;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("gnt_id", 32'(gnt_id), (m_own < 0) ? 0 : m_own);
    chk("busy", 32'(busy), 32'(m_own >= 0));
    chk("timeout", 32'(timeout), 32'(m_to));
    chk("turnaround", 32'(prev != '0 && gnt != '0 && gnt != prev), 0);
    if (timeout) n_to++;
    new_ten = prev == '0 && gnt != '0;
    for (int i = 0; i < N; i++) begin
      if (rs || !r[i] || gnt[i]) wc[i] = 0;
      else if (new_ten) wc[i]++;
    end
    for (int i = 0; i < N; i++) if (wc[i] > N) chk("wait_bound", 32'(wc[i]), N);
    prev = gnt;
  endtask
  initial begin
    for (int i = 0; i < N; i++) wc[i] = 0;
    step('0, 1'b1);
    step('0, 1'b1);
    chk("reset_gnt", 32'(gnt), 0);
    chk("reset_busy", 32'(busy), 0);
    step(4'b0100, 1'b0);
    chk("first_gnt", 32'(gnt), 32'h4);
    chk("first_id", 32'(gnt_id), 2);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    // ptr now 3: new contender 0 and 3 -> 3 wins
    step(4'b1001, 1'b0);
    chk("ptr_after_2", 32'(gnt), 32'h8);
    step(4'b0000, 1'b0);
    step('0, 1'b1);
    step(4'b1111, 1'b0);
    chk("rot_start", 32'(gnt), 32'h1);
    for (int t = 0; t < 8; t++) begin
      step(4'b1111, 1'b0);
      step(4'b1111 ^ (4'b1 << (t % 4)), 1'b0);
      chk("rot_gap", 32'(gnt), 0);
      step(4'b1111, 1'b0);
      chk("rot_order", 32'(gnt), 32'(1 << ((t + 1) % 4)));
    end
    step('0, 1'b1);
    step(4'b0010, 1'b0);
    for (int t = 0; t < 3; t++) begin
      step(4'b1011, 1'b0);
      chk("no_preempt", 32'(gnt), 32'h2);
    end
    step(4'b1001, 1'b0);
    chk("release_gap", 32'(gnt), 0);
    step(4'b1001, 1'b0);
    chk("skip_idle_req", 32'(gnt), 32'h8);
    step(4'b1000, 1'b0);
    step(4'b1000, 1'b1);
    chk("mid_reset_gnt", 32'(gnt), 0);
    chk("mid_reset_id", 32'(gnt_id), 0);
    chk("mid_reset_busy", 32'(busy), 0);
    step(4'b1001, 1'b0);
    chk("post_reset", 32'(gnt), 32'h1);
    step('0, 1'b1);
    n_to = 0;
    for (int t = 0; t < 40; t++) begin
      step(4'b0011, 1'b0);
`ifndef BUS_RR_ARB_TIMEOUT_EN
      chk("unbounded_hold", 32'(gnt), 32'h1);
`endif
    end
    chk("timeout_count", n_to, TO_EN ? 2 : 0);
    step('0, 1'b1);
    for (int c = 0; c < 10000; c++) begin
      logic [N-1:0] r;
      r = req;
      for (int i = 0; i < N; i++) if ($urandom_range(3) == 0) r[i] = ~r[i];
      step(r, $urandom_range(499) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
